fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the single-cycle/multicycle datapath. It replaces the fixed 5-bit PC register with a configurable-width PC and a reset vector. It talks to instruction memory over a req/ack handshake, so variable-latency memory is supported. Fetched instructions are delivered through a one-entry valid/ready output buffer, and a redirect input (branch/jump) squashes in-flight work.

## Interface
- ADDR_W, 32, PC/address width in bits (≥ 3)
- INSTR_W, 32, instruction width in bits
- RESET_PC, 0, PC value loaded on reset (ADDR_W bits, low 2 bits must be 0)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- redirect  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_W  target address; bits [1:0] ignored (treated as 0)
- imem_req  out  1  fetch request outstanding
- imem_addr  out  ADDR_W  address of outstanding request
- imem_ack  in  1  one-cycle pulse: imem_rdata valid for current request
- imem_rdata  in  INSTR_W  instruction word
- instr_valid  out  1  output buffer holds an instruction
- instr_ready  in  1  consumer accepts instruction this cycle
- instr  out  INSTR_W  buffered instruction
- instr_pc  out  ADDR_W  address of buffered instruction
- pc  out  ADDR_W  address of next fetch to issue

## Operation
- Registers: pc, req_addr, state, and the output buffer (instr, instr_pc, instr_valid).
- States: IDLE (no request), BUSY (request outstanding, result kept), FLUSH (request outstanding, result discarded).
- imem_req = (state != IDLE); imem_addr = req_addr. Both stay stable until ack.
- slot_free = !instr_valid || instr_ready. A transfer occurs when instr_valid && instr_ready; then instr_valid clears unless refilled.
- IDLE, no redirect, slot_free: req_addr ← pc, go to BUSY.
- IDLE, no redirect, !slot_free: stay in IDLE.
- BUSY, ack, no redirect:
  - instr ← imem_rdata; instr_pc ← req_addr; instr_valid ← 1
  - pc ← req_addr + 4; go to IDLE
  - The buffer is guaranteed empty here, because issue required slot_free.
- BUSY, no ack: hold.
- FLUSH, ack: discard data; go to IDLE.
- redirect (highest priority, any state):
  - pc ← {redirect_pc[ADDR_W-1:2], 2'b00}
  - instr_valid ← 0, whether or not instr_ready is high
  - IDLE stays IDLE: no issue that cycle.
  - BUSY without ack goes to FLUSH.
  - BUSY with ack, or FLUSH with ack, goes to IDLE, and the data is discarded.
  - FLUSH without ack stays in FLUSH.
- Arithmetic: pc + 4 is modulo 2^ADDR_W. 0xFFFF_FFFC wraps to 0x0000_0000.
- imem_ack in IDLE is ignored.

## Timing
- Reset values:
  - state = IDLE, pc = RESET_PC, req_addr = RESET_PC
  - instr_valid = 0, instr = 0, instr_pc = 0
  - imem_req = 0, imem_addr = RESET_PC
- First request: reset deasserted in cycle 0 → imem_req high in cycle 1 with imem_addr = RESET_PC.
- Latency: ack in cycle N → instr_valid high in cycle N+1.
- Throughput with a zero-wait memory (ack in the first req cycle) and instr_ready held high: one instruction per 2 cycles.
- Redirect in cycle N → first request to the target is issued in cycle N+2, or later if a FLUSH is pending.
- Reset mid-operation: all state returns to reset values on the next edge. An outstanding request is abandoned; imem is reset on the same signal.
- Outputs are registered except imem_req/imem_addr, which decode directly from registers. There is no combinational path from inputs to outputs.

## Structure
- Package fetch_pkg:
  - state enum (IDLE, BUSY, FLUSH)
  - INSTR_BYTES = 4
- Sub-module pc_reg: ADDR_W-wide register with synchronous reset to a parameter value and a load enable. Used for pc and req_addr.
- The FSM and output buffer live in fetch_unit.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory returning data = addr, ready=1 → instr_pc sequence 0x100, 0x104, 0x108 with instr equal to instr_pc, one valid every 2 cycles.
- Memory latency 3 cycles → imem_addr held at 0x104 for 3 cycles; instr_valid high the cycle after ack.
- instr_ready=0 for 5 cycles while valid → instr/instr_pc stable, imem_req stays 0, pc holds 0x104. Ready=1 → next fetch of 0x104 is issued.
- redirect to 0x2003 during BUSY (no ack) → FLUSH; the late ack data is dropped; next request is 0x2000; instr_valid cleared the cycle after redirect.
- Simultaneous redirect and ack in BUSY → ack data discarded, state IDLE, pc=0x2000. Also redirect while valid && ready → buffer cleared.
- ADDR_W=32, RESET_PC=0xFFFFFFFC → second fetch address is 0x00000000. Asserting reset mid-fetch → imem_req=0 and pc=RESET_PC next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM state encoding and fetch stride.
// No latency or backpressure of its own; these are types and constants only.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Address register with synchronous reset to RESET_VAL and a load enable.
// The new value is visible one cycle after load_i. It holds its value whenever load_i is low.
module pc_reg #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] d_i,
    output logic [ADDR_W-1:0] q_o
);

    logic [ADDR_W-1:0] value_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= RESET_VAL;
        end else if (load_i) begin
            value_q <= d_i;
        end
    end

    assign q_o = value_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: req/ack to imem, one-entry valid/ready output buffer, redirect squashes in-flight work.
// An ack lands in the buffer one cycle later. A full, unaccepted buffer blocks the next issue.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  pc
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, req_addr_q;
    logic               pc_load, req_load;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_pc_q;
    logic               instr_valid_q, valid_d, buf_load;
    logic               slot_free;

    pc_reg #(.ADDR_W(ADDR_W), .RESET_VAL(RESET_PC)) u_pc (
        .clk    (clk),
        .reset  (reset),
        .load_i (pc_load),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    pc_reg #(.ADDR_W(ADDR_W), .RESET_VAL(RESET_PC)) u_req_addr (
        .clk    (clk),
        .reset  (reset),
        .load_i (req_load),
        .d_i    (pc_q),
        .q_o    (req_addr_q)
    );

    assign slot_free = !instr_valid_q || instr_ready;

    always_comb begin
        state_d  = state_q;
        pc_load  = 1'b0;
        pc_d     = pc_q;
        req_load = 1'b0;
        buf_load = 1'b0;
        valid_d  = instr_valid_q && !instr_ready;

        if (redirect) begin
            // Redirect wins over everything: buffer dropped, any ack this cycle is discarded.
            pc_load = 1'b1;
            pc_d    = redirect_pc & ~ADDR_W'(3);
            valid_d = 1'b0;
            case (state_q)
                BUSY, FLUSH: state_d = imem_ack ? IDLE : FLUSH;
                default:     state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (slot_free) begin
                        req_load = 1'b1;
                        state_d  = BUSY;
                    end
                end
                BUSY: begin
                    if (imem_ack) begin
                        buf_load = 1'b1;
                        valid_d  = 1'b1;
                        pc_load  = 1'b1;
                        pc_d     = req_addr_q + ADDR_W'(INSTR_BYTES);
                        state_d  = IDLE;
                    end
                end
                FLUSH: begin
                    if (imem_ack) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            instr_valid_q <= valid_d;
            if (buf_load) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= req_addr_q;
            end
        end
    end

    assign imem_req    = (state_q != IDLE);
    assign imem_addr   = req_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a transaction-level model.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic [31:0] w_pc;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc          (pc)
    );

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .redirect    (w_redirect),
        .redirect_pc (w_redirect_pc),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (w_ack),
        .imem_rdata  (w_rdata),
        .instr_valid (w_valid),
        .instr_ready (w_ready),
        .instr       (w_instr),
        .instr_pc    (w_instr_pc),
        .pc          (w_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_idle(input logic rdy);
        redirect      = 1'b0;
        redirect_pc   = '0;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        instr_ready   = rdy;
        w_ack         = 1'b0;
        w_rdata       = '0;
        w_ready       = 1'b1;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
    endtask

    // Leaves the bench at the negedge of cycle 1 (first request visible).
    task automatic do_reset(input logic rdy);
        reset = 1'b1;
        drive_idle(rdy);
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle(1'b1);
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr: got %h want 100", imem_addr); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h want 100", pc); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        reset = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL first_addr: got %h want 100", imem_addr); end
    endtask

    task automatic test_zero_wait();
        logic        e_req, e_valid;
        logic [31:0] e_pc;
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            e_req   = ((k % 2) == 0);
            e_valid = ((k % 2) == 1);
            e_pc    = 32'h100 + 32'(4 * ((k - 1) / 2));
            checks++; if (imem_req !== e_req) begin errors++; $display("FAIL zw_req k=%0d: got %b want %b", k, imem_req, e_req); end
            checks++; if (instr_valid !== e_valid) begin errors++; $display("FAIL zw_valid k=%0d: got %b want %b", k, instr_valid, e_valid); end
            if (e_valid) begin
                checks++; if (instr_pc !== e_pc) begin errors++; $display("FAIL zw_instr_pc k=%0d: got %h want %h", k, instr_pc, e_pc); end
                checks++; if (instr !== e_pc) begin errors++; $display("FAIL zw_instr k=%0d: got %h want %h", k, instr, e_pc); end
            end
            imem_ack   = imem_req;
            imem_rdata = imem_addr;
            tick();
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_latency();
        do_reset(1'b1);
        imem_ack = 1'b1; imem_rdata = 32'h100;
        tick();
        imem_ack = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL lat_req i=%0d: got %b want 1", i, imem_req); end
            checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL lat_addr i=%0d: got %h want 104", i, imem_addr); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL lat_valid i=%0d: got %b want 0", i, instr_valid); end
            imem_ack   = (i == 2);
            imem_rdata = 32'h1234_0104;
            tick();
        end
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL lat_valid_after_ack: got %b want 1", instr_valid); end
        checks++; if (instr_pc !== 32'h104) begin errors++; $display("FAIL lat_instr_pc: got %h want 104", instr_pc); end
        checks++; if (instr !== 32'h1234_0104) begin errors++; $display("FAIL lat_instr: got %h want 12340104", instr); end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        imem_ack = 1'b1; imem_rdata = 32'hA5A5_0100;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid i=%0d: got %b want 1", i, instr_valid); end
            checks++; if (instr !== 32'hA5A5_0100) begin errors++; $display("FAIL bp_instr i=%0d: got %h want a5a50100", i, instr); end
            checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL bp_instr_pc i=%0d: got %h want 100", i, instr_pc); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req i=%0d: got %b want 0", i, imem_req); end
            checks++; if (pc !== 32'h104) begin errors++; $display("FAIL bp_pc i=%0d: got %h want 104", i, pc); end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL bp_release_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL bp_release_addr: got %h want 104", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", instr_valid); end
    endtask

    task automatic test_redirect_flush();
        do_reset(1'b1);
        redirect = 1'b1; redirect_pc = 32'h2003;
        tick();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fl_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL fl_addr: got %h want 100", imem_addr); end
        checks++; if (pc !== 32'h2000) begin errors++; $display("FAIL fl_pc: got %h want 2000", pc); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b want 0", instr_valid); end
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fl_hold_req: got %b want 1", imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fl_drop_req: got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fl_drop_valid: got %b want 0", instr_valid); end
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fl_new_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h2000) begin errors++; $display("FAIL fl_new_addr: got %h want 2000", imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h2000;
        tick();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h2000) begin errors++; $display("FAIL fl_deliver: got valid=%b pc=%h want 1/2000", instr_valid, instr_pc); end
    endtask

    task automatic test_redirect_ack();
        do_reset(1'b1);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        redirect = 1'b1; redirect_pc = 32'h2000;
        tick();
        imem_ack = 1'b0; redirect = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ra_req: got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ra_valid: got %b want 0", instr_valid); end
        checks++; if (pc !== 32'h2000) begin errors++; $display("FAIL ra_pc: got %h want 2000", pc); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin errors++; $display("FAIL ra_issue: got req=%b addr=%h want 1/2000", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h600D_2000;
        tick();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h600D_2000) begin errors++; $display("FAIL ra_deliver: got valid=%b instr=%h want 1/600d2000", instr_valid, instr); end
        redirect = 1'b1; redirect_pc = 32'h3001;
        tick();
        redirect = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ra_clear_valid: got %b want 0", instr_valid); end
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL ra_clear_pc: got %h want 3000", pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ra_idle_req: got %b want 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL ra_issue2: got req=%b addr=%h want 1/3000", imem_req, imem_addr); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset(1'b1);
        checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_first: got req=%b addr=%h want 1/fffffffc", w_req, w_addr); end
        w_ack = 1'b1; w_rdata = 32'hCAFE_0000;
        tick();
        w_ack = 1'b0;
        checks++; if (w_pc !== 32'h0) begin errors++; $display("FAIL wr_pc: got %h want 0", w_pc); end
        checks++; if (w_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC || w_instr !== 32'hCAFE_0000) begin errors++; $display("FAIL wr_deliver: got %b/%h/%h want 1/fffffffc/cafe0000", w_valid, w_instr_pc, w_instr); end
        tick();
        checks++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin errors++; $display("FAIL wr_second: got req=%b addr=%h want 1/0", w_req, w_addr); end
        reset = 1'b1;
        tick();
        checks++; if (w_req !== 1'b0 || w_pc !== 32'hFFFF_FFFC || w_valid !== 1'b0) begin errors++; $display("FAIL wr_midreset: got req=%b pc=%h valid=%b want 0/fffffffc/0", w_req, w_pc, w_valid); end
        checks++; if (imem_req !== 1'b0 || pc !== 32'h100) begin errors++; $display("FAIL main_midreset: got req=%b pc=%h want 0/100", imem_req, pc); end
        reset = 1'b0;
    endtask

    // Transaction model: expected next-fetch pc, outstanding request, delivery queue.
    task automatic test_random();
        logic [31:0] q_addr[$];
        logic [31:0] q_data[$];
        logic [31:0] exp_pc, mem_addr, data, tgt;
        logic        mem_busy, flushed, rdy, red, ack;
        int          lat, cnt, delivered;
        exp_pc = 32'h100; mem_addr = '0; mem_busy = 1'b0; flushed = 1'b0;
        lat = 0; cnt = 0; delivered = 0;
        do_reset(1'b1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++; if (instr_valid !== (q_addr.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d: got %b want %b", cyc, instr_valid, q_addr.size() != 0); end
            if (instr_valid === 1'b1 && q_addr.size() != 0) begin
                checks++; if (instr_pc !== q_addr[0] || instr !== q_data[0]) begin errors++; $display("FAIL rnd_data cyc=%0d: got %h/%h want %h/%h", cyc, instr_pc, instr, q_addr[0], q_data[0]); end
            end
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d: got %h want %h", cyc, pc, exp_pc); end
            if (imem_req === 1'b1) begin
                if (!mem_busy) begin
                    checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_issue cyc=%0d: got %h want %h", cyc, imem_addr, exp_pc); end
                    mem_busy = 1'b1; mem_addr = exp_pc; lat = int'($urandom_range(0, 3)); cnt = 0;
                end else begin
                    checks++; if (imem_addr !== mem_addr) begin errors++; $display("FAIL rnd_addr_stable cyc=%0d: got %h want %h", cyc, imem_addr, mem_addr); end
                end
            end
            rdy  = ($urandom_range(0, 3) != 0);
            red  = ($urandom_range(0, 15) == 0);
            tgt  = $urandom;
            data = $urandom;
            if (imem_req === 1'b1) begin
                ack = (cnt == lat);
                cnt++;
            end else begin
                ack = ($urandom_range(0, 7) == 0);
            end
            instr_ready = rdy; redirect = red; redirect_pc = tgt;
            imem_ack = ack; imem_rdata = data;
            if (red) begin
                q_addr.delete(); q_data.delete();
                exp_pc = tgt & ~32'h3;
                if (mem_busy && !ack) flushed = 1'b1;
            end else begin
                if (q_addr.size() != 0 && rdy) begin
                    void'(q_addr.pop_front()); void'(q_data.pop_front());
                    delivered++;
                end
                if (mem_busy && ack && !flushed) begin
                    q_addr.push_back(mem_addr); q_data.push_back(data);
                    exp_pc = mem_addr + 32'd4;
                end
            end
            if (mem_busy && ack) begin
                mem_busy = 1'b0; flushed = 1'b0;
            end
            tick();
        end
        drive_idle(1'b1);
        checks++; if (delivered < 100) begin errors++; $display("FAIL rnd_progress: got %0d deliveries want >= 100", delivered); end
    endtask

    initial begin
        reset = 1'b1;
        drive_idle(1'b1);
        test_reset();
        test_zero_wait();
        test_latency();
        test_backpressure();
        test_redirect_flush();
        test_redirect_ack();
        test_wrap_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
